// File: rtl/pc_sequencer.sv
// Program-counter sequencer: relative branches, call/return through a circular
// return-address stack, RUN/HALTED sequencing, and saturating cycle/retired counters.
module pc_sequencer #(
    parameter int PC_W      = 10,
    parameter int JUMP_W    = 8,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_en,
    input  logic              branch_taken,
    input  logic              jump_dir,
    input  logic [JUMP_W-1:0] jump_amt,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic              halt_req,
    output logic [PC_W-1:0]   pc,
    output logic              halt,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic [CNT_W-1:0]  cycle_ct,
    output logic [CNT_W-1:0]  retired_ct
);

    localparam int PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RCNT_W  = $clog2(RAS_DEPTH + 1);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(RAS_DEPTH);
    localparam logic [RCNT_W-1:0] RCNT_ONE = RCNT_W'(1);
    localparam logic [PC_W-1:0]   PC_ONE   = PC_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [0:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [RCNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [PC_W-1:0]   ras_q [RAS_DEPTH];
    logic              ras_we;
    logic [PTR_W-1:0]  top_ptr;
    logic [PC_W-1:0]   pc_plus1;
    logic [PC_W-1:0]   amt_ext;
    logic [PC_W-1:0]   target;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_ONE;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_MAX : p - PTR_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_ONE;
    endfunction

    // Sums are PC_W wide, so both jump directions wrap modulo 2^PC_W.
    assign amt_ext  = PC_W'(jump_amt);
    assign pc_plus1 = pc_q + PC_ONE;
    assign target   = jump_dir ? (pc_q - amt_ext) : (pc_q + amt_ext);
    assign top_ptr  = ptr_dec(wr_ptr_q);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wr_ptr_d  = wr_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        cycle_d   = cycle_q;
        retired_d = retired_q;
        ras_we    = 1'b0;

        if (state_q == ST_RUN) begin
            cycle_d = sat_inc(cycle_q);
            if (!stall) begin
                retired_d = sat_inc(retired_q);
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (ret_en) begin
                    if (ras_cnt_q != '0) begin
                        pc_d      = ras_q[top_ptr];
                        wr_ptr_d  = top_ptr;
                        ras_cnt_d = ras_cnt_q - RCNT_ONE;
                    end else begin
                        unf_d   = 1'b1;
                        state_d = ST_HALTED;
                    end
                end else if (call_en) begin
                    // A push into a full stack overwrites the oldest slot; count stays at depth.
                    ras_we   = 1'b1;
                    pc_d     = target;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                    if (ras_cnt_q == RCNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        ras_cnt_d = ras_cnt_q + RCNT_ONE;
                    end
                end else if (branch_en && branch_taken) begin
                    pc_d = target;
                end else begin
                    pc_d = pc_plus1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (start) begin
            state_q   <= ST_RUN;
            pc_q      <= '0;
            wr_ptr_q  <= '0;
            ras_cnt_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wr_ptr_q  <= wr_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    // NOTE: stack storage is not reset; ras_cnt_q guards every read, so stale entries are never used.
    always_ff @(posedge CLK) begin
        if (ras_we && !start) begin
            ras_q[wr_ptr_q] <= pc_plus1;
        end
    end

    assign pc            = pc_q;
    assign halt          = (state_q == ST_HALTED);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign cycle_ct      = cycle_q;
    assign retired_ct    = retired_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the current program-counter logic. Owns the PC, relative branches, call/return through an internal return-address stack, halt sequencing, and the cycle and retired-instruction counters that currently live loose in the top level. Sits between the control unit/ALU (branch, call, ret and halt requests) and the instruction ROM (pc out). Adds a stall handshake and stack error reporting that the current PC logic does not have.

Parameters:
PC_W, 10, PC width; instruction ROM depth is 2^PC_W.
JUMP_W, 8, width of the relative jump amount (unsigned magnitude).
RAS_DEPTH, 4, return-address stack entries (>=1).
CNT_W, 16, width of the cycle and retired-instruction counters.

Ports:
CLK  input  1  clock, posedge.
start  input  1  synchronous active-high reset.
stall  input  1  hold current instruction; PC, RAS and retired_ct do not advance.
branch_en  input  1  current instruction is a conditional branch.
branch_taken  input  1  comparison result; used only when branch_en=1.
jump_dir  input  1  0 = forward (pc+amt), 1 = backward (pc-amt).
jump_amt  input  JUMP_W  relative jump magnitude, zero-extended to PC_W.
call_en  input  1  push pc+1 and take a relative jump.
ret_en  input  1  pop the RAS into pc.
halt_req  input  1  current instruction is HALT.
pc  output  PC_W  address to the instruction ROM.
halt  output  1  high while in HALTED.
ras_overflow  output  1  sticky; a push occurred while the RAS was full.
ras_underflow  output  1  sticky; a pop occurred while the RAS was empty.
cycle_ct  output  CNT_W  cycles spent in RUN.
retired_ct  output  CNT_W  instructions retired.

Behaviour:
- start=1 at a posedge overrides everything and takes effect at that edge, including mid-call or while HALTED.
- Reset values: pc=0, halt=0, ras_overflow=0, ras_underflow=0, cycle_ct=0, retired_ct=0, RAS count=0, state=RUN.
- Two states: RUN and HALTED. HALTED exits only via start.
- In HALTED, pc, RAS, counters and flags are frozen and all request inputs are ignored.
- All outputs are registered. pc updates at the posedge that ends the instruction cycle; a ROM read of the new pc is valid the following cycle.
- RUN with stall=1: pc, RAS and retired_ct hold, cycle_ct increments. All other request inputs are ignored that cycle.
- RUN with stall=0 retires one instruction: retired_ct+1 and cycle_ct+1. Action priority, highest first:
  1. halt_req: state goes to HALTED and pc holds. The HALT instruction counts as retired.
  2. ret_en, RAS non-empty: pc <= top of stack, pop.
  3. ret_en, RAS empty: ras_underflow<=1, state goes to HALTED, pc holds. The instruction counts as retired.
  4. call_en: push pc+1 (mod 2^PC_W), pc <= target.
  5. branch_en & branch_taken: pc <= target.
  6. Otherwise, including branch_en with branch_taken=0: pc <= pc+1.
- Target = pc + zext(jump_amt) if jump_dir=0, else pc - zext(jump_amt), computed modulo 2^PC_W (wraps both ways). jump_amt=0 with a taken branch is a legal self-loop.
- RAS push when full: ras_overflow<=1. The oldest entry is discarded (circular buffer), the new entry becomes the top, and the count stays RAS_DEPTH.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Lower-priority requests asserted together with a higher-priority one have no effect that cycle.

Test Plan:
- Reset, then 5 cycles with no requests -> pc=5, cycle_ct=5, retired_ct=5, halt=0.
- Branches:
  - At pc=3, branch_en=1, taken=1, dir=1, amt=2 -> pc=1.
  - Then dir=0, amt=4 -> pc=5.
  - Then branch_en=1, taken=0 -> pc=6.
- Wrap (PC_W=10):
  - At pc=1020, taken, fwd, amt=8 -> pc=4.
  - At pc=2, taken, bwd, amt=5 -> pc=1021.
- Call/return (RAS_DEPTH=4):
  - call at pc=7, fwd, amt=10 -> pc=17; ret -> pc=8.
  - 5 nested calls -> ras_overflow=1; 4 rets return to the 4 most recent return addresses.
  - 5th ret -> ras_underflow=1, halt=1, pc unchanged.
- Stall and halt:
  - stall held 3 cycles at pc=4 -> pc=4, cycle_ct +3, retired_ct unchanged.
  - halt_req at pc=9 -> halt=1 the next cycle, pc=9, counters frozen for 10 further cycles.
- Reset mid-run: start asserted while HALTED, or with call_en=1 in the same cycle -> the next edge gives pc=0, halt=0, flags=0, counters=0, RAS empty.
